// File: rtl/phase_accumulator_nco.sv
// phase_accumulator_nco
//   NCO-style phase accumulator for the CDR loop.
//   - The accumulator holds PHASE_W integer phase bits above FRAC_W fractional bits.
//   - Each enabled cycle it advances by a programmable frequency control word (FCW).
//   - Early/late nudges from the phase detector move the phase by +/-ADJ_STEP.
//   - NPH equally spaced phase taps feed the multi-phase sampler.
//   - wrap and slip are one-cycle strobes for a forward carry and a backward borrow.
//
// Optional build macro: PHASE_DITHER_EN
//   When it is defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) is added.
//   The LFSR is seeded with 16'hACE1 on reset and steps on every enabled cycle.
//   Its low min(FRAC_W,16) bits are added into the fractional sum as an unsigned term.
//   The dither term takes part in wrap detection.
//
// Reset: rst is synchronous and active-low (0 = reset, sampled on posedge clk).
//   Reset has priority over every other input.

module phase_accumulator_nco #(
    parameter int                          PHASE_W     = 8,
    parameter int                          FRAC_W      = 8,
    parameter int                          NPH         = 4,
    parameter logic [PHASE_W+FRAC_W-1:0]   FCW_DEFAULT = 16'h0100,
    parameter logic [PHASE_W+FRAC_W-1:0]   ADJ_STEP    = 16'h0010
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           fcw_load,
    input  logic [PHASE_W+FRAC_W-1:0]      fcw_in,
    input  logic                           adj_up,
    input  logic                           adj_dn,
    output logic [PHASE_W-1:0]             phase,
    output logic [NPH*PHASE_W-1:0]         phase_taps,
    output logic                           wrap,
    output logic                           slip
);

    localparam int ACC_W = PHASE_W + FRAC_W;

    // The sum is kept three bits wider than the accumulator and read as two's complement.
    // The worst case is acc + FCW + ADJ_STEP + dither, which can approach 3*2^ACC_W.
    // Two extra bits would not hold that without aliasing into the sign bit.
    // The top bit is therefore the borrow (a negative sum).
    // The bits between it and ACC_W flag a carry.
    localparam int SUM_W = ACC_W + 3;

    localparam logic [SUM_W-1:0] ADJ_POS = {3'b000, ADJ_STEP};
    localparam logic [SUM_W-1:0] ADJ_NEG = -ADJ_POS;

    // Spacing between adjacent taps, in integer phase LSBs.
    localparam int TAP_STEP = (1 << PHASE_W) / NPH;

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] fcw_reg;
    logic [ACC_W-1:0] fcw_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             slip_reg;
    logic             slip_next;

    logic [SUM_W-1:0] acc_ext;
    logic [SUM_W-1:0] inc_term;
    logic [SUM_W-1:0] adj_term;
    logic [SUM_W-1:0] dither_term;
    logic [SUM_W-1:0] sum;

`ifdef PHASE_DITHER_EN
    // With FRAC_W=0 there are no fractional bits to dither.
    // The LFSR still runs in that case, so its sequence does not depend on FRAC_W.
    localparam int DITH_W = (FRAC_W < 16) ? FRAC_W : 16;

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    // The Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1) shifts only on enabled cycles.
    always_comb begin
        lfsr_next = lfsr_reg;
        if (en) begin
            lfsr_next = {lfsr_reg[14:0],
                         lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    // The LFSR state register is re-seeded on every reset, so a run after reset is reproducible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    generate
        if (DITH_W > 0) begin : g_dither
            assign dither_term = en ? {{(SUM_W-DITH_W){1'b0}}, lfsr_reg[DITH_W-1:0]}
                                    : '0;
        end else begin : g_no_dither
            assign dither_term = '0;
        end
    endgenerate
`else
    assign dither_term = '0;
`endif

    // Build the terms of the sum.
    // The nudge is sign-extended so that a backward step can produce a borrow.
    always_comb begin
        acc_ext  = {3'b000, acc_reg};
        inc_term = '0;
        if (en) begin
            inc_term = {3'b000, fcw_reg};
        end
        adj_term = '0;
        case ({adj_up, adj_dn})
            2'b10:   adj_term = ADJ_POS;
            2'b01:   adj_term = ADJ_NEG;
            default: adj_term = '0;
        endcase
    end

    // Form the next accumulator value and classify it as a carry, a borrow, or neither.
    always_comb begin
        sum       = acc_ext + inc_term + adj_term + dither_term;
        acc_next  = sum[ACC_W-1:0];
        slip_next = sum[SUM_W-1];
        wrap_next = ~sum[SUM_W-1] & (|sum[SUM_W-2:ACC_W]);
    end

    // A new FCW is latched at this edge.
    // The increment computed in the load cycle still uses the old word.
    always_comb begin
        fcw_next = fcw_reg;
        if (fcw_load) begin
            fcw_next = fcw_in;
        end
    end

    // Update the accumulator, FCW and strobe registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg  <= '0;
            fcw_reg  <= FCW_DEFAULT;
            wrap_reg <= 1'b0;
            slip_reg <= 1'b0;
        end else begin
            acc_reg  <= acc_next;
            fcw_reg  <= fcw_next;
            wrap_reg <= wrap_next;
            slip_reg <= slip_next;
        end
    end

    assign phase = acc_reg[ACC_W-1 -: PHASE_W];
    assign wrap  = wrap_reg;
    assign slip  = slip_reg;

    // Each tap is the integer phase plus a fixed offset, taken modulo 2^PHASE_W.
    // The taps add no latency beyond the accumulator register.
    generate
        for (genvar gi = 0; gi < NPH; gi++) begin : g_tap
            localparam logic [PHASE_W-1:0] TAP_OFFSET = PHASE_W'(gi * TAP_STEP);
            assign phase_taps[gi*PHASE_W +: PHASE_W] = phase + TAP_OFFSET;
        end
    endgenerate

endmodule

// File: tb/tb_phase_accumulator_nco.sv
// Testbench for phase_accumulator_nco with default parameters and dither disabled.
// Stimulus records carry their expected phase and strobe values.
// Each expectation is pushed to a scoreboard queue when its inputs are driven.
// It is popped and compared one cycle later, once the registered outputs have updated.
// Tap expectations are derived from the expected phase using fixed offsets of 0x40.

module tb_phase_accumulator_nco;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fcw_load;
    logic [15:0] fcw_in;
    logic        adj_up;
    logic        adj_dn;
    logic [7:0]  phase;
    logic [31:0] phase_taps;
    logic        wrap;
    logic        slip;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        r;
        logic        e;
        logic        l;
        logic [15:0] f;
        logic        u;
        logic        d;
        logic [7:0]  ph;
        logic        w;
        logic        s;
    } vec_t;

    typedef struct {
        string       name;
        logic [7:0]  ph;
        logic        w;
        logic        s;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[22];

    phase_accumulator_nco dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fcw_load   (fcw_load),
        .fcw_in     (fcw_in),
        .adj_up     (adj_up),
        .adj_dn     (adj_dn),
        .phase      (phase),
        .phase_taps (phase_taps),
        .wrap       (wrap),
        .slip       (slip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic r, input logic e, input logic l,
                                input logic [15:0] f, input logic u, input logic d,
                                input logic [7:0] ph, input logic w, input logic s);
        vec_t v;
        v.name = n; v.r = r; v.e = e; v.l = l; v.f = f;
        v.u = u; v.d = d; v.ph = ph; v.w = w; v.s = s;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue its expectation.
    // After the next edge, pop the expectation and compare it against the outputs.
    task automatic apply(input vec_t v);
        exp_t        x;
        logic [31:0] et;
        rst      = v.r;
        en       = v.e;
        fcw_load = v.l;
        fcw_in   = v.f;
        adj_up   = v.u;
        adj_dn   = v.d;
        x.name = v.name; x.ph = v.ph; x.w = v.w; x.s = v.s;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            et[k*8 +: 8] = x.ph + 8'(k * 64);
        end
        $display("%s: rst=%b en=%b ld=%b fcw_in=%04h up=%b dn=%b -> phase=%02h taps=%08h wrap=%b slip=%b",
                 x.name, v.r, v.e, v.l, v.f, v.u, v.d, phase, phase_taps, wrap, slip);
        check({x.name, ".phase"}, 32'(phase), 32'(x.ph));
        check({x.name, ".taps"},  phase_taps, et);
        check({x.name, ".wrap"},  32'(wrap), 32'(x.w));
        check({x.name, ".slip"},  32'(slip), 32'(x.s));
    endtask

    initial begin
        // FCW reload from acc=0. The load cycle still uses the old FCW of 0x0100.
        tbl[0]  = mk("reload_rst",  0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[1]  = mk("reload_load", 1, 1, 1, 16'h0280, 0, 0, 8'h01, 0, 0);
        tbl[2]  = mk("reload_1",    1, 1, 0, 16'h0000, 0, 0, 8'h03, 0, 0);
        tbl[3]  = mk("reload_2",    1, 1, 0, 16'h0000, 0, 0, 8'h06, 0, 0);
        tbl[4]  = mk("reload_3",    1, 1, 0, 16'h0000, 0, 0, 8'h08, 0, 0);
        tbl[5]  = mk("reload_4",    1, 1, 0, 16'h0000, 0, 0, 8'h0B, 0, 0);
        tbl[6]  = mk("reload_5",    1, 1, 0, 16'h0000, 0, 0, 8'h0D, 0, 0);
        // Underflow from acc=0: the result is 0xFFF0, tap1 is 0x3F, and slip pulses for one cycle.
        tbl[7]  = mk("under_rst",   0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[8]  = mk("under_dn",    1, 0, 0, 16'h0000, 0, 1, 8'hFF, 0, 1);
        tbl[9]  = mk("under_hold",  1, 0, 0, 16'h0000, 0, 0, 8'hFF, 0, 0);
        // Overflow with a nudge. Set acc to 0xFFF8, then 0xFFF8+0x100-0x10 gives 0x100E8.
        tbl[10] = mk("over_rst",    0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[11] = mk("over_dn",     1, 0, 0, 16'h0000, 0, 1, 8'hFF, 0, 1);
        tbl[12] = mk("over_ld8",    1, 0, 1, 16'h0008, 0, 0, 8'hFF, 0, 0);
        tbl[13] = mk("over_step8",  1, 1, 0, 16'h0000, 0, 0, 8'hFF, 0, 0);
        tbl[14] = mk("over_ld100",  1, 0, 1, 16'h0100, 0, 0, 8'hFF, 0, 0);
        tbl[15] = mk("over_wrap",   1, 1, 0, 16'h0000, 0, 1, 8'h00, 1, 0);
        tbl[16] = mk("over_hold",   1, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        // With FCW=0 and en=1 the accumulator is static and wrap never asserts.
        tbl[17] = mk("fcw0_rst",    0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[18] = mk("fcw0_load",   1, 0, 1, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[19] = mk("fcw0_run",    1, 1, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[20] = mk("fcw0_run",    1, 1, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        tbl[21] = mk("fcw0_run",    1, 1, 0, 16'h0000, 0, 0, 8'h00, 0, 0);

        rst = 1'b0; en = 1'b0; fcw_load = 1'b0; fcw_in = '0; adj_up = 1'b0; adj_dn = 1'b0;

        // Hold reset for 10 cycles: phase stays 0 and the taps read C0/80/40/00.
        for (int i = 0; i < 10; i++) begin
            apply(mk("reset", 0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0));
        end

        // Free-run with the default FCW: phase counts up by one.
        // On the 256th enabled cycle it returns to 0 and wrap pulses once.
        for (int i = 1; i <= 257; i++) begin
            apply(mk("freerun", 1, 1, 0, 16'h0000, 0, 0, 8'(i), (i == 256), 0));
        end

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i]);
        end

        // Nudge with en=0: sixteen steps of 0x10 move the phase by one integer LSB.
        apply(mk("nudge_rst", 0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            apply(mk("nudge_up", 1, 0, 0, 16'h0000, 1, 0, 8'((k * 16) >> 8), 0, 0));
        end
        apply(mk("nudge_cancel", 1, 0, 0, 16'h0000, 1, 1, 8'h01, 0, 0));
        apply(mk("nudge_hold",   1, 0, 0, 16'h0000, 0, 0, 8'h01, 0, 0));

        // Mid-run reset. Load 0x0280, then run 50 cycles.
        // The reset cycle also tries to load 0x0400; reset must win.
        // The next enabled cycle must then step by the default FCW of 0x0100.
        apply(mk("mid_rst",  0, 0, 0, 16'h0000, 0, 0, 8'h00, 0, 0));
        apply(mk("mid_load", 1, 1, 1, 16'h0280, 0, 0, 8'h01, 0, 0));
        for (int i = 1; i <= 50; i++) begin
            apply(mk("mid_run", 1, 1, 0, 16'h0000, 0, 0,
                     8'((32'h0100 + i * 32'h0280) >> 8), 0, 0));
        end
        apply(mk("mid_reset",  0, 1, 1, 16'h0400, 1, 0, 8'h00, 0, 0));
        apply(mk("post_reset", 1, 1, 0, 16'h0000, 0, 0, 8'h01, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
